// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store unit and data_mem_responder.
// The master drives requests; the slave returns data, ready and error.
interface data_mem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  dAddress;
    logic [31:0] dWriteData;
    logic [3:0]  dByteMask;
    logic [31:0] dReadData;
    logic        mem_ready;
    logic        mem_err;

    modport master (
        output MemRead,
        output MemWrite,
        output dAddress,
        output dWriteData,
        output dByteMask,
        input  dReadData,
        input  mem_ready,
        input  mem_err
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  dAddress,
        input  dWriteData,
        input  dByteMask,
        output dReadData,
        output mem_ready,
        output mem_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with a fixed wait-state response.
// Define DMEM_BYTE_MASK_EN to enable per-byte write enables.
module data_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_next;

    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic [3:0]       r_mask;
    logic             r_write;
    logic             r_err;
    logic [31:0]      r_rdata;

    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             w_req;
    logic             w_accept;
    logic             w_req_err;
    logic [IDX_W-1:0] w_req_idx;

    logic [IDX_W-1:0] w_op_idx;
    logic [31:0]      w_op_wdata;
    logic [3:0]       w_op_mask;
    logic             w_op_write;
    logic             w_op_err;

    logic             w_enter_resp;
    logic             w_commit;
    logic [3:0]       w_wbe;

    assign w_req     = bus.MemRead | bus.MemWrite;
    assign w_accept  = (r_state == S_IDLE) & w_req;
    assign w_req_err = (bus.MemRead & bus.MemWrite)
                     | (bus.dAddress[1:0] != 2'b00);
    assign w_req_idx =
        IDX_W'({25'd0, bus.dAddress[8:2]} % DEPTH_WORDS);

    // With zero wait states RESP is entered on the accepting edge,
    // so the live request must be used there instead of the latches.
    always_comb begin
        w_op_idx   = r_idx;
        w_op_wdata = r_wdata;
        w_op_mask  = r_mask;
        w_op_write = r_write;
        w_op_err   = r_err;
        if (r_state == S_IDLE) begin
            w_op_idx   = w_req_idx;
            w_op_wdata = bus.dWriteData;
            w_op_mask  = bus.dByteMask;
            w_op_write = bus.MemWrite;
            w_op_err   = w_req_err;
        end
    end

`ifdef DMEM_BYTE_MASK_EN
    assign w_wbe = w_op_mask;
`else
    // Full-word writes: the mask is carried but always overridden.
    assign w_wbe = 4'hF | w_op_mask;
`endif

    assign w_enter_resp = ~rst
                        & (w_state_next == S_RESP)
                        & (r_state != S_RESP);
    assign w_commit     = w_enter_resp & w_op_write & ~w_op_err;

    // Next-state and wait counter decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES > 0) begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = CNT_LOAD;
                    end else begin
                        w_state_next = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, counter and response data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_err <= w_req_err;
            end
            if (w_enter_resp) begin
                if (w_op_err) begin
                    r_rdata <= 32'd0;
                end else if (!w_op_write) begin
                    r_rdata <= r_mem[w_op_idx];
                end
            end
        end
    end

    // Request latches; they only matter while an access is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_mask  <= 4'd0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= w_req_idx;
            r_wdata <= bus.dWriteData;
            r_mask  <= bus.dByteMask;
            r_write <= bus.MemWrite;
        end
    end

    // Storage: not reset, so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wbe[b]) begin
                    r_mem[w_op_idx][8*b +: 8] <= w_op_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.mem_ready = (r_state == S_RESP);
    assign bus.mem_err   = (r_state == S_RESP) & r_err;
    assign bus.dReadData = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of transactions on a
// 2-wait-state instance plus reset and zero-wait corner sequences.
module tb_data_mem_responder;
    localparam int WC = 2;

`ifdef DMEM_BYTE_MASK_EN
    localparam logic [31:0] MASKED = 32'h11BB33DD;
`else
    localparam logic [31:0] MASKED = 32'hAABBCCDD;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    data_mem_responder_if bus ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(
        .WAIT_CYCLES(WC),
        .DEPTH_WORDS(128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    data_mem_responder #(
        .WAIT_CYCLES(0),
        .DEPTH_WORDS(128)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [8:0]  addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic txn(input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] d,
                       input logic [3:0] m, output int lat,
                       output logic [31:0] rdata, output logic err);
        bus.MemRead    = rd;
        bus.MemWrite   = wr;
        bus.dAddress   = a;
        bus.dWriteData = d;
        bus.dByteMask  = m;
        @(posedge clk);
        #1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        lat = 1;
        while (!bus.mem_ready && lat < 20) begin
            chk("err_without_ready", {31'd0, bus.mem_err}, 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.mem_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got none after %0d cycles", lat);
            lat = -1;
        end
        rdata = bus.dReadData;
        err   = bus.mem_err;
        @(posedge clk);
        #1;
        chk("ready_single_pulse", {31'd0, bus.mem_ready}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] rdata;
        logic        err;

        vecs[0]  = '{1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 9'h010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 9'h013, 32'h0,        4'hF, 32'h0,        1'b1};
        vecs[3]  = '{1'b1, 1'b0, 9'h010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 9'h020, 32'h0BADF00D, 4'hF, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 9'h020, 32'h12345678, 4'hF, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 1'b0, 9'h020, 32'h0,        4'hF, 32'h0BADF00D, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 9'h004, 32'h11223344, 4'hF, 32'h0BADF00D, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 9'h004, 32'hAABBCCDD, 4'h5, 32'h0BADF00D, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 9'h004, 32'h0,        4'hF, MASKED,       1'b0};
        vecs[10] = '{1'b0, 1'b1, 9'h040, 32'h55AA55AA, 4'hF, MASKED,       1'b0};
        vecs[11] = '{1'b0, 1'b1, 9'h042, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[12] = '{1'b1, 1'b0, 9'h040, 32'h0,        4'hF, 32'h55AA55AA, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 9'h004, 32'h0,        4'hF, MASKED,       1'b0};

        rst = 1'b1;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.dAddress    = 9'h0;
        bus.dWriteData  = 32'h0;
        bus.dByteMask   = 4'h0;
        bus0.MemRead    = 1'b0;
        bus0.MemWrite   = 1'b0;
        bus0.dAddress   = 9'h0;
        bus0.dWriteData = 32'h0;
        bus0.dByteMask  = 4'hF;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("reset_err", {31'd0, bus.mem_err}, 32'd0);
        chk("reset_rdata", bus.dReadData, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                vecs[i].mask, lat, rdata, err);
            chk($sformatf("v%0d_latency", i), lat, WC + 1);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), {31'd0, err},
                {31'd0, vecs[i].exp_err});
        end

        bus.MemWrite   = 1'b1;
        bus.dAddress   = 9'h040;
        bus.dWriteData = 32'hCAFEF00D;
        bus.dByteMask  = 4'hF;
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
        chk("abort_wait_ready", {31'd0, bus.mem_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_rdata_cleared", bus.dReadData, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("abort_no_ready_%0d", i),
                {31'd0, bus.mem_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        txn(1'b1, 1'b0, 9'h040, 32'h0, 4'hF, lat, rdata, err);
        chk("abort_read_old", rdata, 32'h55AA55AA);
        chk("abort_read_err", {31'd0, err}, 32'd0);

        rst = 1'b1;
        bus.MemRead  = 1'b1;
        bus.dAddress = 9'h010;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_ignores_req_%0d", i),
                {31'd0, bus.mem_ready}, 32'd0);
        end
        rst = 1'b0;
        bus.MemRead = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_idle_%0d", i),
                {31'd0, bus.mem_ready}, 32'd0);
        end

        bus0.MemWrite   = 1'b1;
        bus0.dAddress   = 9'h008;
        bus0.dWriteData = 32'h13579BDF;
        @(posedge clk);
        #1;
        bus0.MemWrite = 1'b0;
        chk("w0_write_ready", {31'd0, bus0.mem_ready}, 32'd1);
        chk("w0_write_err", {31'd0, bus0.mem_err}, 32'd0);
        @(posedge clk);
        #1;
        chk("w0_write_ready_low", {31'd0, bus0.mem_ready}, 32'd0);

        bus0.MemRead = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("w0_hold_ready_%0d", i),
                {31'd0, bus0.mem_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("w0_hold_err_%0d", i),
                {31'd0, bus0.mem_err}, 32'd0);
            if (i % 2 == 0) begin
                chk($sformatf("w0_hold_rdata_%0d", i),
                    bus0.dReadData, 32'h13579BDF);
            end
        end
        bus0.MemRead = 1'b0;
        @(posedge clk);
        #1;
        chk("w0_idle_after_hold", {31'd0, bus0.mem_ready}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the number of wait-state cycles between request acceptance and response (legal range 0..15).
REQ-002 Parameter DEPTH_WORDS, default 128, SHALL set the storage depth in 32-bit words (byte address space 4*DEPTH_WORDS, 512 bytes at default).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset; it is synchronous and active-high.
REQ-005 MemRead  input  1  SHALL request a word read when high in IDLE.
REQ-006 MemWrite  input  1  SHALL request a word write when high in IDLE.
REQ-007 dAddress  input  9  SHALL be the byte address of the access.
REQ-008 dWriteData  input  32  SHALL be the store data.
REQ-009 dByteMask  input  4  SHALL be the per-byte write enables (bit i = byte i, little-endian); ignored unless DMEM_BYTE_MASK_EN is defined.
REQ-010 dReadData  output  32  SHALL be the read data, valid when mem_ready is high.
REQ-011 mem_ready  output  1  SHALL pulse high for exactly one cycle to complete each accepted request.
REQ-012 mem_err  output  1  SHALL be high together with mem_ready when the completed request was illegal.

Function
REQ-013 The block SHALL implement states IDLE, WAIT, RESP.
REQ-014 In IDLE, MemRead or MemWrite high SHALL accept the request: latch dAddress, dWriteData, dByteMask and the operation; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 In WAIT, a counter loaded with WAIT_CYCLES-1 at acceptance SHALL decrement each cycle; at zero the next state SHALL be RESP.
REQ-016 Latency: request seen in IDLE at edge N SHALL give mem_ready high in cycle N+1+WAIT_CYCLES.
REQ-017 In RESP, mem_ready SHALL be 1 for that cycle only; next state SHALL be IDLE unconditionally.
REQ-018 Requests SHALL NOT be accepted in WAIT or RESP; input changes there SHALL be ignored; a request held high into IDLE after RESP SHALL be accepted as a new request.
REQ-019 Word index SHALL be dAddress[8:2] modulo DEPTH_WORDS.
REQ-020 A write SHALL commit to storage on the edge entering RESP; a read SHALL load dReadData on the same edge.
REQ-021 dReadData SHALL hold its value until the next completed read or error response.
REQ-022 Error conditions SHALL be: MemRead and MemWrite both high at acceptance, or dAddress[1:0] != 0.
REQ-023 On error: no storage write, dReadData = 0 in RESP, mem_err = 1 with mem_ready.
REQ-024 mem_err SHALL be 0 in every cycle where mem_ready is 0.

Reset
REQ-025 rst high SHALL force state IDLE, counter 0, mem_ready 0, mem_err 0, dReadData 0 on the next edge.
REQ-026 Reset during WAIT SHALL abort the access; no write SHALL commit and no mem_ready SHALL be issued.
REQ-027 Reset SHALL NOT clear storage contents.
REQ-028 While rst is high, MemRead/MemWrite SHALL be ignored.

Configuration
REQ-029 With DMEM_BYTE_MASK_EN defined, a write SHALL update only bytes whose dByteMask bit is 1; mask 4'b0000 SHALL complete normally with no change.
REQ-030 Without DMEM_BYTE_MASK_EN, every write SHALL update all 4 bytes regardless of dByteMask.

Verification
REQ-031 WAIT_CYCLES=2: write 32'hDEADBEEF at 9'h010, then read 9'h010 -> each mem_ready exactly 3 cycles after acceptance; read returns 32'hDEADBEEF, mem_err 0.
REQ-032 Read at 9'h013 (misaligned) -> mem_ready and mem_err high together, dReadData 32'h0; word at 9'h010 unchanged.
REQ-033 MemRead and MemWrite both high at 9'h020 with data 32'h12345678 -> mem_err 1; subsequent read of 9'h020 returns prior contents.
REQ-034 Write 32'hCAFEF00D at 9'h040, assert rst during WAIT, then read 9'h040 -> no mem_ready for aborted write; read returns old contents.
REQ-035 DMEM_BYTE_MASK_EN defined: word 32'h11223344 at 9'h004, write 32'hAABBCCDD with mask 4'b0101 -> read returns 32'h11BB33DD; undefined -> 32'hAABBCCDD.
REQ-036 WAIT_CYCLES=0, MemRead held high 4 cycles at 9'h008 -> mem_ready pulses every second cycle (accept, RESP, accept, RESP), never two consecutive cycles.
